// File: rtl/uart_echo.sv
// Byte-echo peer for the uart block: received bytes are queued in a small FIFO and replayed on tx.
// Optional build macro UART_ECHO_UPCASE_EN upcases ASCII a..z as each byte is popped for transmit.
module uart_echo #(
    parameter int FIFO_AW = 3
) (
    input  logic               clk_50m,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               rx_rdy,
    input  logic [7:0]         rx_dout,
    output logic               rx_rdy_clr,
    output logic [7:0]         tx_din,
    output logic               tx_wr_en,
    input  logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    input  logic               ovf_clr
);

    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {R_IDLE, R_CLR, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_WAIT_BUSY, T_WAIT_DONE} tx_state_t;

    rx_state_t          rx_state_q, rx_state_d;
    tx_state_t          tx_state_q, tx_state_d;
    logic [FIFO_AW:0]   wptr_q, wptr_d;
    logic [FIFO_AW:0]   rptr_q, rptr_d;
    logic               rx_rdy_clr_q, rx_rdy_clr_d;
    logic               tx_wr_en_q, tx_wr_en_d;
    logic [7:0]         tx_din_q, tx_din_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         mem_q [DEPTH];

    logic               push, pop, drop, rx_take, full, empty;

    function automatic logic [7:0] upcase(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) begin
            return b ^ 8'h20;
        end
`endif
        return b;
    endfunction

    // Full is judged on the pre-pop pointers, so a push while full drops even with a pop.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q   <= R_IDLE;
            tx_state_q   <= T_IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            rx_rdy_clr_q <= 1'b0;
            tx_wr_en_q   <= 1'b0;
            tx_din_q     <= 8'h00;
            overflow_q   <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            tx_state_q   <= tx_state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            rx_rdy_clr_q <= rx_rdy_clr_d;
            tx_wr_en_q   <= tx_wr_en_d;
            tx_din_q     <= tx_din_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (push) begin
            mem_q[wptr_q[FIFO_AW-1:0]] <= rx_dout;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            R_IDLE:  if (rx_rdy) rx_state_d = R_CLR;
            R_CLR:   rx_state_d = R_WAIT;
            R_WAIT:  if (!rx_rdy) rx_state_d = R_IDLE;
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rx_take      = (rx_state_q == R_IDLE) && rx_rdy;
        push         = rx_take && !full;
        drop         = rx_take && full;
        rx_rdy_clr_d = (rx_state_d == R_CLR);
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            T_IDLE:      if (enable && !empty && !tx_busy) tx_state_d = T_LOAD;
            T_LOAD:      tx_state_d = T_WAIT_BUSY;
            T_WAIT_BUSY: if (tx_busy) tx_state_d = T_WAIT_DONE;
            T_WAIT_DONE: if (!tx_busy) tx_state_d = T_IDLE;
            default:     tx_state_d = T_IDLE;
        endcase
    end

    // tx_wr_en is registered from T_LOAD, which gives the fixed three-cycle echo latency.
    always_comb begin
        pop        = (tx_state_q == T_IDLE) && enable && !empty && !tx_busy;
        tx_din_d   = pop ? upcase(mem_q[rptr_q[FIFO_AW-1:0]]) : tx_din_q;
        tx_wr_en_d = (tx_state_q == T_LOAD);
    end

    always_comb begin
        wptr_d = wptr_q + {{FIFO_AW{1'b0}}, push};
        rptr_d = rptr_q + {{FIFO_AW{1'b0}}, pop};
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    assign rx_rdy_clr = rx_rdy_clr_q;
    assign tx_wr_en   = tx_wr_en_q;
    assign tx_din     = tx_din_q;
    assign overflow   = overflow_q;
    assign fifo_level = wptr_q - rptr_q;

endmodule

// File: tb/tb_uart_echo.sv
// Self-checking bench for uart_echo: table vectors, hand-written corner sequences and a
// randomized run checked against a queue-based model of the echo behaviour.
module tb_uart_echo;

    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    logic          clk_50m = 1'b0;
    logic          rst_n   = 1'b0;
    logic          enable  = 1'b0;
    logic          rx_rdy  = 1'b0;
    logic [7:0]    rx_dout = 8'h00;
    logic          ovf_clr = 1'b0;
    logic          rx_rdy_clr;
    logic [7:0]    tx_din;
    logic          tx_wr_en;
    logic          tx_busy;
    logic [AW:0]   fifo_level;
    logic          overflow;

    uart_echo #(.FIFO_AW(AW)) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .enable     (enable),
        .rx_rdy     (rx_rdy),
        .rx_dout    (rx_dout),
        .rx_rdy_clr (rx_rdy_clr),
        .tx_din     (tx_din),
        .tx_wr_en   (tx_wr_en),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #10 clk_50m = ~clk_50m;

    // Transmitter stand-in: busy rises the cycle after wr_en and lasts busy_len cycles.
    logic        busy_m   = 1'b0;
    int          busy_cnt = 0;
    int          busy_len = 3;
    int          clr_cnt  = 0;
    logic [7:0]  got_q[$];

    assign tx_busy = busy_m;

    always @(posedge clk_50m) begin
        if (rx_rdy_clr) clr_cnt <= clr_cnt + 1;
        if (tx_wr_en) begin
            got_q.push_back(tx_din);
            busy_m   <= 1'b1;
            busy_cnt <= busy_len;
        end else if (busy_m) begin
            if (busy_cnt <= 1) busy_m <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end
    end

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t        tbl [8];
    int          passed = 0;
    int          total  = 0;
    logic [7:0]  exp_q[$];
    int          got_rd = 0;
    bit          model_ovf = 1'b0;
    int          sent = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    function automatic logic [7:0] ref_up(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    // Bytes held by the echo = accepted but not yet seen on the transmitter.
    function automatic int model_occ();
        return exp_q.size() - (got_q.size() - got_rd);
    endfunction

    task automatic model_rx(input logic [7:0] b);
        if (model_occ() >= DEPTH) model_ovf = 1'b1;
        else exp_q.push_back(b);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic clr_with);
        int n;
        @(negedge clk_50m);
        model_rx(b);
        rx_dout = b;
        rx_rdy  = 1'b1;
        ovf_clr = clr_with;
        @(posedge clk_50m); #1;
        ovf_clr = 1'b0;
        n = 0;
        while (!rx_rdy_clr && n < 20) begin
            @(posedge clk_50m); #1;
            n++;
        end
        if (n >= 20) check("rdy_clr_timeout", 0, 1);
        @(posedge clk_50m); #1;
        rx_rdy = 1'b0;
        sent++;
        @(posedge clk_50m); #1;
    endtask

    task automatic drain_verify(input string nm);
        int n;
        n = 0;
        while (n < 5000 && !((got_q.size() - got_rd) == exp_q.size() &&
                             fifo_level == 0 && !tx_busy)) begin
            @(posedge clk_50m); #1;
            n++;
        end
        repeat (3) @(posedge clk_50m);
        #1;
        check({nm, "_drained"}, int'(n < 5000), 1);
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            check(nm, int'(got_q[got_rd]), int'(ref_up(exp_q.pop_front())));
            got_rd++;
        end
    endtask

    initial begin
        int wr_k, clr_at, c0, base, n0, n;
        logic [7:0] din_at;

        tbl[0] = '{8'h61, 8'h61};
        tbl[1] = '{8'h7A, 8'h7A};
        tbl[2] = '{8'h41, 8'h41};
        tbl[3] = '{8'h7B, 8'h7B};
        tbl[4] = '{8'h60, 8'h60};
        tbl[5] = '{8'h6D, 8'h6D};
        tbl[6] = '{8'h00, 8'h00};
        tbl[7] = '{8'hFF, 8'hFF};
`ifdef UART_ECHO_UPCASE_EN
        tbl[0].exp = 8'h41;
        tbl[1].exp = 8'h5A;
        tbl[5].exp = 8'h4D;
`endif

        // Reset state
        repeat (3) @(posedge clk_50m);
        #1;
        check("rst_rdy_clr", int'(rx_rdy_clr), 0);
        check("rst_wr_en", int'(tx_wr_en), 0);
        check("rst_din", int'(tx_din), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ovf", int'(overflow), 0);
        @(negedge clk_50m);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(posedge clk_50m);

        // Single byte latency
        c0 = clr_cnt;
        @(negedge clk_50m);
        model_rx(8'h5A);
        rx_dout = 8'h5A;
        rx_rdy  = 1'b1;
        wr_k = 0; clr_at = 0; din_at = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk_50m); #1;
            if (clr_at != 0 && k == clr_at + 1) rx_rdy = 1'b0;
            if (rx_rdy_clr && clr_at == 0) clr_at = k;
            if (tx_wr_en && wr_k == 0) begin
                wr_k   = k;
                din_at = tx_din;
            end
        end
        sent++;
        check("latency_cycles", wr_k, 3);
        check("latency_din", int'(din_at), int'(ref_up(8'h5A)));
        drain_verify("single_echo");
        check("single_clr_pulses", clr_cnt - c0, 1);
        check("single_level", int'(fifo_level), 0);

        // Fill with transmit blocked, then overflow and clear
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i), 1'b0);
            check("fill_level", int'(fifo_level), model_occ());
        end
        check("fill_full_level", int'(fifo_level), 8);
        check("fill_no_ovf", int'(overflow), 0);
        send_byte(8'h08, 1'b0);
        check("drop_level", int'(fifo_level), 8);
        check("drop_ovf", int'(overflow), int'(model_ovf));
        send_byte(8'h09, 1'b1);
        check("drop_and_clr_set_wins", int'(overflow), 1);
        @(negedge clk_50m);
        ovf_clr = 1'b1;
        @(posedge clk_50m); #1;
        ovf_clr = 1'b0;
        model_ovf = 1'b0;
        check("ovf_cleared", int'(overflow), 0);
        enable = 1'b1;
        drain_verify("fill_order");
        check("fill_count", got_rd, 9);

        // Table vectors through the echo path
        base = got_rd;
        for (int i = 0; i < 8; i++) send_byte(tbl[i].din, 1'b0);
        drain_verify("tbl_model");
        for (int i = 0; i < 8; i++) begin
            if (base + i < got_q.size()) check("tbl_vec", int'(got_q[base + i]), int'(tbl[i].exp));
            else check("tbl_vec_missing", 0, 1);
        end
        check("tbl_din_hold", int'(tx_din), int'(tbl[7].exp));

        // Reset while transmitter busy with bytes queued and overflow set
        enable   = 1'b0;
        busy_len = 30;
        for (int i = 0; i < 9; i++) send_byte(8'hA0 + 8'(i), 1'b0);
        check("pre_rst_ovf", int'(overflow), 1);
        enable = 1'b1;
        n = 0;
        while (!tx_wr_en && n < 20) begin
            @(posedge clk_50m); #1;
            n++;
        end
        check("pre_rst_wr_seen", int'(n < 20), 1);
        repeat (4) @(posedge clk_50m);
        @(negedge clk_50m);
        rst_n = 1'b0;
        #1;
        check("midrst_level", int'(fifo_level), 0);
        check("midrst_wr_en", int'(tx_wr_en), 0);
        check("midrst_din", int'(tx_din), 0);
        check("midrst_ovf", int'(overflow), 0);
        if (got_rd < got_q.size()) check("midrst_first", int'(got_q[got_rd]), int'(ref_up(8'hA0)));
        else check("midrst_first_missing", 0, 1);
        got_rd = got_q.size();
        exp_q.delete();
        model_ovf = 1'b0;
        repeat (2) @(posedge clk_50m);
        @(negedge clk_50m);
        rst_n = 1'b1;
        n0 = got_q.size();
        repeat (80) @(posedge clk_50m);
        #1;
        check("no_stale_tx", got_q.size(), n0);
        check("post_rst_level", int'(fifo_level), 0);
        busy_len = 2;

        // Loopback of every byte value, then random bytes, with random pacing
        for (int i = 0; i < 256; i++) begin
            busy_len = $urandom_range(1, 3);
            send_byte(8'(i), 1'b0);
            repeat ($urandom_range(6, 10)) @(posedge clk_50m);
        end
        drain_verify("loop_all");
        for (int i = 0; i < 64; i++) begin
            busy_len = $urandom_range(1, 3);
            send_byte(8'($urandom_range(0, 255)), 1'b0);
            repeat ($urandom_range(6, 10)) @(posedge clk_50m);
        end
        drain_verify("loop_rand");
        #1;
        check("loop_ovf", int'(overflow), int'(model_ovf));
        check("loop_level", int'(fifo_level), 0);
        check("clr_pulse_total", clr_cnt, sent);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
